game_input_controller: RTL
==========================

// Module: game_input_controller
// PURPOSE
// Parametrised game input front end. Replaces the single-key interrupt generator between the board pins and the CPU.
// Synchronises and debounces NUM_KEYS buttons and generates the game frame tick internally.
// On each tick, queues one frame interrupt plus one interrupt per newly pressed key into a FIFO.
// The CPU drains the FIFO over a valid/ready port.
// PARAMETERS
// NUM_KEYS        4            number of button inputs (1..31)
// SYS_FREQ        100000000    clk frequency, Hz
// FRAME_RATE      60           frame ticks per second; SYS_FREQ/FRAME_RATE must exceed NUM_KEYS+2
// DEBOUNCE_CYCLES 1000000      consecutive stable cycles before a debounced level changes (>=1)
// FIFO_DEPTH      8            interrupt queue depth, power of two, >=2
// INT_OPCODE      5'b10110     instruction bits [31:27]
// INT_RD          5'd28        instruction bits [26:22]
// REPEAT_FRAMES   15           auto-repeat period in frames (GAME_AUTO_REPEAT_EN only)
// PORTS
// clk            in   1                      system clock
// reset          in   1                      asynchronous, active-low reset
// keys_in        in   NUM_KEYS               raw asynchronous buttons, 1 = pressed
// int_ready      in   1                      CPU accepts head entry this cycle
// clear_overflow in   1                      clears overflow flag
// int_valid      out  1                      FIFO non-empty
// int_instr      out  32                     head entry
// frame_tick     out  1                      one-cycle pulse at FRAME_RATE
// key_state      out  NUM_KEYS               debounced levels
// fifo_count     out  $clog2(FIFO_DEPTH)+1   occupancy
// overflow       out  1                      sticky: an event was dropped
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, FIFO empty, counters 0, pending bits 0, FSM IDLE.
// - Sync: 2-flop synchroniser per key. Debounce: per-key counter reloads whenever the synced level equals key_state.
//   key_state flips after DEBOUNCE_CYCLES consecutive differing cycles.
//   Latency from pin to key_state is 2+DEBOUNCE_CYCLES cycles.
// - Press event: rising edge of key_state[k] sets pending[k]. A set in the same cycle as a clear wins.
// - Frame counter: counts 0..SYS_FREQ/FRAME_RATE-1. frame_tick is high on the cycle the count wraps.
//   The first tick occurs SYS_FREQ/FRAME_RATE cycles after reset release.
// - FSM IDLE->SCAN on frame_tick:
//   - Copies pending into snap and clears pending, except for bits set that cycle.
//   - Pushes frame entry id=0 in the same cycle.
// - FSM SCAN: one cycle per key, k ascending. If snap[k], pushes id=k+1. After k=NUM_KEYS-1, returns to IDLE.
// - Entry format: {INT_OPCODE, INT_RD, 22-bit id}, zero-extended.
// - FIFO:
//   - First-word fall-through: int_instr is valid in the cycle after the push.
//   - Pop when int_valid && int_ready.
//   - A push when full is allowed only if a pop occurs the same cycle. Otherwise the entry is dropped and overflow is set.
//   - int_instr = 0 when empty.
// - overflow: clear_overflow clears it. If a drop occurs in the same cycle as clear_overflow, the flag stays set.
// - int_ready while empty: ignored. fifo_count never wraps.
// CONFIGURATION
// GAME_AUTO_REPEAT_EN defined:
// - Per-key frame counter runs while key_state[k]=1.
// - Every REPEAT_FRAMES frame ticks of continuous hold, pending[k] is set again.
// - The counter clears when the key is released.
// GAME_AUTO_REPEAT_EN undefined: only rising edges of key_state create events. No repeat logic is synthesised.
// TESTING (SYS_FREQ=1000, FRAME_RATE=10 -> tick every 100 cycles; DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, NUM_KEYS=4)
// 1. Reset, no keys:
//    - All outputs 0.
//    - frame_tick at cycle 100 after release.
//    - Next cycle int_valid=1, int_instr=32'hB7000000.
//    - Pop with int_ready=1 -> int_valid=0.
// 2. key0 glitch of 3 cycles -> key_state[0] stays 0.
//    key0 held -> key_state[0]=1 exactly 6 cycles after the pin edge. No further events while held.
// 3. key2 then key0 pressed within one frame -> after the tick, the FIFO holds ids 0, 1, 3 in that order.
//    fifo_count=3, then drains to 0.
// 4. int_ready=0, all 4 keys pressed -> the tick pushes 4 entries, then 1 drop.
//    Result: overflow=1, fifo_count=4. clear_overflow pulse -> overflow=0.
// 5. Reset asserted during SCAN -> int_valid, fifo_count and key_state go 0 immediately (async).
//    The next tick comes 100 cycles after release.
// 6. With GAME_AUTO_REPEAT_EN and REPEAT_FRAMES=2: hold key1 for 6 frames -> id 2 entries appear:
//    - on the first tick after press;
//    - then every 2nd tick;
//    - none after release.

Source files
------------

// File: rtl/game_input_controller.sv
// game_input_controller: game input front end.
// Synchronises and debounces NUM_KEYS buttons, generates the frame tick, and on every tick
// queues one frame interrupt (id 0) plus one interrupt per newly pressed key (id k+1) into a
// first-word-fall-through FIFO drained by the CPU over a valid/ready port.
// Optional feature: define GAME_AUTO_REPEAT_EN to re-raise a key event every REPEAT_FRAMES
// frame ticks while the key stays held.
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   keys_i           raw asynchronous buttons, 1 = pressed
//   int_ready_i      CPU accepts the head entry this cycle
//   clear_overflow_i clears the sticky overflow flag
//   int_valid_o      FIFO non-empty
//   int_instr_o      head entry {INT_OPCODE, INT_RD, 22-bit id}, 0 when empty
//   frame_tick_o     one-cycle pulse at FRAME_RATE
//   key_state_o      debounced key levels
//   fifo_count_o     FIFO occupancy
//   overflow_o       sticky: an event was dropped
module game_input_controller #(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned SYS_FREQ        = 100000000,
   parameter int unsigned FRAME_RATE      = 60,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter logic [4:0]  INT_OPCODE      = 5'b10110,
   parameter logic [4:0]  INT_RD          = 5'd28
`ifdef GAME_AUTO_REPEAT_EN
   , parameter int unsigned REPEAT_FRAMES = 15
`endif
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_KEYS-1:0]             keys_i,
   input  logic                            int_ready_i,
   input  logic                            clear_overflow_i,
   output logic                            int_valid_o,
   output logic [31:0]                     int_instr_o,
   output logic                            frame_tick_o,
   output logic [NUM_KEYS-1:0]             key_state_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
   output logic                            overflow_o
);

   localparam int unsigned FramePeriod = SYS_FREQ / FRAME_RATE;
   localparam int unsigned FrameW      = $clog2(FramePeriod);
   localparam int unsigned DbW         = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned IdxW        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int unsigned IdW         = $clog2(NUM_KEYS + 1);
   localparam int unsigned PtrW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW        = PtrW + 1;

   typedef enum logic {StIdle, StScan} state_e;

   // ---------------- synchroniser and debounce ----------------
   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] key_state_q, key_state_d;
   logic [DbW-1:0]      db_cnt_q [NUM_KEYS];
   logic [DbW-1:0]      db_cnt_d [NUM_KEYS];

   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         db_cnt_d[k]    = db_cnt_q[k];
         key_state_d[k] = key_state_q[k];
         if (sync2_q[k] == key_state_q[k]) begin
            db_cnt_d[k] = '0;
         end else if (db_cnt_q[k] == DbW'(DEBOUNCE_CYCLES - 1)) begin
            // this is the DEBOUNCE_CYCLES-th consecutive differing cycle
            key_state_d[k] = sync2_q[k];
            db_cnt_d[k]    = '0;
         end else begin
            db_cnt_d[k] = db_cnt_q[k] + DbW'(1);
         end
      end
   end

   // ---------------- frame counter ----------------
   logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
   logic              tick_q, frame_wrap;

   assign frame_wrap  = (frame_cnt_q == FrameW'(FramePeriod - 1));
   assign frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + FrameW'(1);

   // ---------------- event sources ----------------
   logic [NUM_KEYS-1:0] ev_set;

`ifdef GAME_AUTO_REPEAT_EN
   localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
   logic [RepW-1:0]     rep_q [NUM_KEYS];
   logic [RepW-1:0]     rep_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] rep_set;

   always_comb begin
      for (int k = 0; k < NUM_KEYS; k++) begin
         rep_d[k]   = rep_q[k];
         rep_set[k] = 1'b0;
         if (!key_state_q[k]) begin
            rep_d[k] = '0;
         end else if (tick_q) begin
            if (rep_q[k] == RepW'(REPEAT_FRAMES - 1)) begin
               rep_set[k] = 1'b1;
               rep_d[k]   = '0;
            end else begin
               rep_d[k] = rep_q[k] + RepW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_KEYS; k++) rep_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) rep_q[k] <= rep_d[k];
      end
   end

   assign ev_set = (key_state_d & ~key_state_q) | rep_set;
`else
   assign ev_set = key_state_d & ~key_state_q;
`endif

   // ---------------- scan FSM ----------------
   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [NUM_KEYS-1:0] pending_q, pending_d, snap_q, snap_d;
   logic                push, clr_pending;
   logic [IdW-1:0]      push_id;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      push        = 1'b0;
      push_id     = '0;
      clr_pending = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tick_q) begin
               snap_d      = pending_q;
               clr_pending = 1'b1;
               push        = 1'b1;
               idx_d       = '0;
               state_d     = StScan;
            end
         end
         StScan: begin
            if (snap_q[idx_q]) begin
               push    = 1'b1;
               push_id = IdW'(idx_q) + IdW'(1);
            end
            if (idx_q == IdxW'(NUM_KEYS - 1)) state_d = StIdle;
            else                              idx_d   = idx_q + IdxW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // a set in the same cycle as the snapshot clear survives
   assign pending_d = (clr_pending ? '0 : pending_q) | ev_set;

   // ---------------- FIFO ----------------
   logic [IdW-1:0]  mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            pop, full, push_ok, drop, overflow_q;

   assign pop     = (count_q != '0) && int_ready_i;
   assign full    = (count_q == CntW'(FIFO_DEPTH));
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CntW'(1);
      else if (!push_ok && pop) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_id;
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         key_state_q <= '0;
         for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
         frame_cnt_q <= '0;
         tick_q      <= 1'b0;
         state_q     <= StIdle;
         idx_q       <= '0;
         pending_q   <= '0;
         snap_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= keys_i;
         sync2_q     <= sync1_q;
         key_state_q <= key_state_d;
         for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
         frame_cnt_q <= frame_cnt_d;
         tick_q      <= frame_wrap;
         state_q     <= state_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         snap_q      <= snap_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q     <= count_d;
         // a drop coinciding with a clear keeps the flag set
         overflow_q  <= drop | (overflow_q & ~clear_overflow_i);
      end
   end

   // ---------------- outputs ----------------
   assign int_valid_o  = (count_q != '0);
   assign int_instr_o  = int_valid_o ? {INT_OPCODE, INT_RD, 22'(mem_q[rd_ptr_q])} : 32'h0;
   assign frame_tick_o = tick_q;
   assign key_state_o  = key_state_q;
   assign fifo_count_o = count_q;
   assign overflow_o   = overflow_q;

endmodule
